countdown_tick_ctrl: RTL and testbench

- Upstream control stage for the start-value down counter.
- Reloads that counter and paces its decrements with a programmable prescaler.
- Supports pause and abort, and watches the counter's zero flag to end a run.
- Emits a one-cycle done pulse on expiry; sits between the game/UI control logic and the countdown.

---
 rtl/countdown_tick_ctrl.sv | 137 +++++++++++++
 tb/tb_countdown_tick_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_tick_ctrl.sv
// rtl/countdown_tick_ctrl.sv - reload, prescaled tick pacing and expiry control for a down counter

module countdown_tick_ctrl #(
    parameter int DIV_W        = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             go,
    input  logic             pause,
    input  logic             abort,
    input  logic [DIV_W-1:0] div_value,
    input  logic             expired,
    output logic             cnt_n_reset,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    // Guard window length; legal GUARD_CYCLES range fits in 4 bits.
    localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [3:0]       guard_q, guard_d;
    logic             cnt_n_reset_q, cnt_n_reset_d;
    logic             tick_q,        tick_d;
    logic             running_q,     running_d;
    logic             paused_q,      paused_d;
    logic             done_q,        done_d;

    // Next-state, prescaler and guard logic; priority abort > expiry > pause > tick.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        div_d   = div_q;
        guard_d = guard_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && !abort) begin
                    state_d = S_LOAD;
                    div_d   = div_value;
                end
            end
            S_LOAD: begin
                presc_d = '0;
                guard_d = GUARD_INIT;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (expired && (guard_q == 4'd0)) begin
                    // Prescaler frozen and the would-be tick dropped.
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    if (presc_q == div_q) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                    if (guard_q != 4'd0) begin
                        guard_d = guard_q - 4'd1;
                    end
                end
            end
            S_PAUSE: begin
                // Prescaler and guard hold so the period resumes where it left off.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        cnt_n_reset_d = (state_d != S_LOAD);
        running_d     = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSE);
        paused_d      = (state_d == S_PAUSE);
        done_d        = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            div_q         <= '0;
            guard_q       <= 4'd0;
            cnt_n_reset_q <= 1'b1;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            paused_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            div_q         <= div_d;
            guard_q       <= guard_d;
            cnt_n_reset_q <= cnt_n_reset_d;
            tick_q        <= tick_d;
            running_q     <= running_d;
            paused_q      <= paused_d;
            done_q        <= done_d;
        end
    end

    assign cnt_n_reset = cnt_n_reset_q;
    assign tick        = tick_q;
    assign running     = running_q;
    assign paused      = paused_q;
    assign done        = done_q;

endmodule

// File: tb/tb_countdown_tick_ctrl.sv
// tb/tb_countdown_tick_ctrl.sv - self-checking bench for countdown_tick_ctrl

module tb_countdown_tick_ctrl;

    localparam int GUARD = 2;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic        clk;
    logic        n_reset;
    logic        go;
    logic        pause;
    logic        abort;
    logic [15:0] div_value;
    logic        expired;
    logic        cnt_n_reset;
    logic        tick;
    logic        running;
    logic        paused;
    logic        done;

    // Behavioural down counter fed by the controller.
    logic [7:0]  start_val = 8'd0;
    logic [7:0]  cnt = 8'd0;
    int          dec_cnt = 0;

    int checks = 0;
    int failures = 0;
    int tick_total = 0;

    // Reference model: run_n counts advancing RUN cycles since reload.
    int          m_mode;
    longint      m_run_n;
    longint      m_div;
    logic        m_tick;

    typedef struct packed {
        logic        go;
        logic        pause;
        logic        abort;
        logic [15:0] dv;
        logic [4:0]  exp;   // {tick, done, running, cnt_n_reset, paused}
    } vec_t;

    vec_t vecs [0:12];

    countdown_tick_ctrl #(.DIV_W(16), .GUARD_CYCLES(GUARD)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .go          (go),
        .pause       (pause),
        .abort       (abort),
        .div_value   (div_value),
        .expired     (expired),
        .cnt_n_reset (cnt_n_reset),
        .tick        (tick),
        .running     (running),
        .paused      (paused),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!cnt_n_reset) begin
            cnt <= start_val;
        end else if (tick && cnt != 8'd0) begin
            cnt     <= cnt - 8'd1;
            dec_cnt <= dec_cnt + 1;
        end
    end

    assign expired = (cnt == 8'd0);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_run_n = 0;
        m_div   = 0;
        m_tick  = 1'b0;
    endtask

    task automatic model_step(input logic g, input logic p, input logic a,
                              input logic [15:0] dv, input logic e);
        m_tick = 1'b0;
        case (m_mode)
            M_IDLE:  if (g && !a) begin m_mode = M_LOAD; m_div = longint'(dv); end
            M_LOAD:  begin m_run_n = 0; m_mode = a ? M_IDLE : M_RUN; end
            M_RUN: begin
                if (a) m_mode = M_IDLE;
                else if (m_run_n >= GUARD && e) m_mode = M_DONE;
                else if (p) m_mode = M_PAUSE;
                else begin
                    m_run_n++;
                    m_tick = ((m_run_n % (m_div + 1)) == 0);
                end
            end
            M_PAUSE: if (a) m_mode = M_IDLE; else if (!p) m_mode = M_RUN;
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_model();
        chk("model_tick",        tick,        m_tick);
        chk("model_done",        done,        m_mode == M_DONE);
        chk("model_running",     running,     m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_PAUSE);
        chk("model_paused",      paused,      m_mode == M_PAUSE);
        chk("model_cnt_n_reset", cnt_n_reset, m_mode != M_LOAD);
    endtask

    // Apply inputs for one cycle, advance the model at the edge, compare just after it.
    task automatic step(input logic g, input logic p, input logic a, input logic [15:0] dv);
        logic e;
        go = g; pause = p; abort = a; div_value = dv;
        e = expired;
        @(posedge clk);
        model_step(g, p, a, dv, e);
        #1;
        check_model();
        if (tick) tick_total++;
    endtask

    // Idle steps until tick (which=0) or done (which=1) is seen; n = steps taken.
    task automatic run_until(input string name, input int which, input int budget,
                             input logic [15:0] dv, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            step(1'b0, 1'b0, 1'b0, dv);
            n++;
            seen = (which == 0) ? tick : done;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tick"},        tick,        0);
        chk({tag, "_done"},        done,        0);
        chk({tag, "_running"},     running,     0);
        chk({tag, "_paused"},      paused,      0);
        chk({tag, "_cnt_n_reset"}, cnt_n_reset, 1);
    endtask

    initial begin
        int   n;
        int   d0;
        int   t0;
        logic acc_a;
        logic acc_b;
        logic [15:0] rdv;

        for (int i = 0; i <= 12; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 16'd3, 5'b00110};
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd3, 5'b00100};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'd3, 5'b10110};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'd3, 5'b10110};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'd3, 5'b01010};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'd3, 5'b00010};

        n_reset = 1'b0; go = 1'b0; pause = 1'b0; abort = 1'b0; div_value = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_reset = 1'b1;

        // div 3, start 2: reload pulse, two ticks 4 apart, done after expiry.
        start_val = 8'd2;
        for (int i = 0; i <= 12; i++) begin
            step(vecs[i].go, vecs[i].pause, vecs[i].abort, vecs[i].dv);
            checks++;
            if ({tick, done, running, cnt_n_reset, paused} !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d: got %b want %b", i,
                         {tick, done, running, cnt_n_reset, paused}, vecs[i].exp);
            end
        end

        // div 0, start 5: back-to-back ticks, exactly five decrements, single done.
        start_val = 8'd5;
        d0 = dec_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd0);
        run_until("t2_done", 1, 40, 16'd0, n);
        chk("t2_decrements", dec_cnt - d0, 5);
        chk("t2_tick_at_done", tick, 0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("t2_idle_running", running, 0);
        chk("t2_single_done", done, 0);

        // div 9, pause 4 cycles into RUN for 20 cycles, resume keeps prescaler.
        start_val = 8'd200;
        step(1'b1, 1'b0, 1'b0, 16'd9);
        step(1'b0, 1'b0, 1'b0, 16'd9);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'd9);
        acc_a = 1'b1;
        acc_b = 1'b0;
        repeat (20) begin
            step(1'b0, 1'b1, 1'b0, 16'd9);
            acc_a &= paused;
            acc_b |= tick;
        end
        chk("t3_paused_level", acc_a, 1);
        chk("t3_no_tick_paused", acc_b, 0);
        run_until("t3_resume_tick", 0, 30, 16'd9, n);
        chk("t3_resume_latency", n, 7);
        step(1'b0, 1'b0, 1'b1, 16'd9);
        chk("t3_abort_running", running, 0);

        // Abort at first tick: no done, then a new go reloads.
        start_val = 8'd3;
        step(1'b1, 1'b0, 1'b0, 16'd2);
        run_until("t4_first_tick", 0, 20, 16'd2, n);
        step(1'b0, 1'b0, 1'b1, 16'd2);
        chk("t4_abort_running", running, 0);
        chk("t4_abort_tick", tick, 0);
        acc_a = 1'b0;
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0, 16'd2);
            acc_a |= done;
        end
        chk("t4_no_done", acc_a, 0);
        step(1'b1, 1'b0, 1'b0, 16'd2);
        chk("t4_reload", cnt_n_reset, 0);
        step(1'b0, 1'b0, 1'b1, 16'd2);
        chk("t4_abort_in_load", running, 0);

        // Start 0, div 7: zero ticks, done after the guard window; go ignored in DONE and with abort.
        start_val = 8'd0;
        t0 = tick_total;
        step(1'b1, 1'b0, 1'b0, 16'd7);
        step(1'b0, 1'b0, 1'b0, 16'd7);
        run_until("t5_done", 1, 20, 16'd7, n);
        chk("t5_done_latency", n, GUARD + 1);
        chk("t5_zero_ticks", tick_total - t0, 0);
        step(1'b1, 1'b0, 1'b0, 16'd7);
        chk("t5_go_in_done_running", running, 0);
        chk("t5_go_in_done_reload", cnt_n_reset, 1);
        step(1'b1, 1'b0, 1'b1, 16'd7);
        chk("t5_abort_go_running", running, 0);
        chk("t5_abort_go_reload", cnt_n_reset, 1);

        // Async reset in the middle of PAUSE, between clock edges.
        start_val = 8'd100;
        step(1'b1, 1'b0, 1'b0, 16'd4);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'd4);
        repeat (2) step(1'b0, 1'b1, 1'b0, 16'd4);
        chk("t6_paused_before_reset", paused, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        pause = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        check_reset_outputs("t6_held");

        // All-ones divide: first tick after 2^16 RUN cycles.
        start_val = 8'd1;
        step(1'b1, 1'b0, 1'b0, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 16'hFFFF);
        run_until("t7_wrap_tick", 0, 70000, 16'hFFFF, n);
        chk("t7_wrap_period", n, 65536);
        run_until("t7_done", 1, 10, 16'hFFFF, n);
        step(1'b0, 1'b0, 1'b0, 16'hFFFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            start_val = 8'($urandom_range(0, 5));
            rdv = ($urandom_range(0, 99) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, rdv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
